// File: rtl/seg_update_master_pkg.sv
// Shared definitions for the 7-segment update master: register offsets,
// digit count, FSM state encoding and small nibble/address helpers.
package seg_pkg;

  localparam logic [11:0] SEG_OFF_DIGIT0   = 12'h000;
  localparam int          SEG_DIGIT_STRIDE = 4;
  localparam logic [11:0] SEG_OFF_SEL      = 12'h020;
  localparam logic [11:0] SEG_OFF_STRB     = 12'h024;
  localparam logic [11:0] SEG_OFF_RES      = 12'h028;
  localparam int          SEG_NUM_DIGITS   = 8;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    SCAN,
    SEL,
    DONE
  } seg_state_t;

  // Nibble idx of a 32-bit display value (nibble 0 = rightmost digit).
  function automatic logic [3:0] seg_nib(input logic [31:0] v, input logic [2:0] idx);
    return v[{idx, 2'b00} +: 4];
  endfunction

  // Peripheral address of digit register idx.
  function automatic logic [31:0] seg_digit_addr(input logic [31:0] base, input logic [2:0] idx);
    return base + {20'b0, SEG_OFF_DIGIT0} + 32'(idx) * 32'(SEG_DIGIT_STRIDE);
  endfunction

endpackage

// File: rtl/seg_update_master_if.sv
// Value handshake plus peripheral write port of the 7-segment update master.
// master: the update block itself; slave: the side that feeds values and
// receives the peripheral transactions.
interface seg_update_master_if;
  logic [31:0] val_i;
  logic        val_valid_i;
  logic        val_ready_o;
  logic        busy_o;
  logic        done_o;
  logic        req_o;
  logic        we_o;
  logic [31:0] addr_o;
  logic [31:0] wdata_o;

  modport master (
    input  val_i, val_valid_i,
    output val_ready_o, busy_o, done_o, req_o, we_o, addr_o, wdata_o
  );

  modport slave (
    output val_i, val_valid_i,
    input  val_ready_o, busy_o, done_o, req_o, we_o, addr_o, wdata_o
  );
endinterface

// File: rtl/seg_update_master_lzb_mask.sv
// Leading-zero blanking mask: bit d is set when any nibble at or above d is
// nonzero, so digits 0..k stay lit where k is the highest nonzero nibble.
// A zero value still lights digit 0.
module seg_lzb_mask
  import seg_pkg::*;
(
  input  logic [31:0]               val,
  output logic [SEG_NUM_DIGITS-1:0] lz
);

  logic [SEG_NUM_DIGITS-1:0] nz;
  logic [SEG_NUM_DIGITS-1:0] lz_raw;

  genvar gi;
  generate
    for (gi = 0; gi < SEG_NUM_DIGITS; gi++) begin : g_dig
      assign nz[gi]     = |val[4*gi +: 4];
      assign lz_raw[gi] = |nz[SEG_NUM_DIGITS-1:gi];
    end
  endgenerate

  // Keep digit 0 lit for an all-zero value.
  assign lz = lz_raw | {{(SEG_NUM_DIGITS-1){1'b0}}, ~(|nz)};

endmodule

// File: rtl/seg_update_master.sv
// 7-segment display update master. Clears the peripheral after reset, then
// for each accepted value writes only the changed digits (one slot per digit)
// followed by a digit-select write and a done pulse.
// Optional build macro SEG_LZB_EN enables leading-zero blanking of the
// select mask.
module seg_update_master
  import seg_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [7:0]  SEL_MASK  = 8'hFF
) (
  input  logic                CLK100,
  input  logic                resetn,
  seg_update_master_if.master bus
);

  seg_state_t  state_reg, state_next;
  logic [2:0]  idx_reg, idx_next;
  logic [31:0] cur_reg, cur_next;
  logic [31:0] shadow_reg, shadow_next;
  logic        req_reg, req_next;
  logic [31:0] addr_reg, addr_next;
  logic [31:0] wdata_reg, wdata_next;
  logic        ready_reg, ready_next;
  logic        busy_reg, busy_next;
  logic        done_reg, done_next;

  logic        load_slot;
  logic [31:0] slot_src;
  logic [2:0]  slot_idx;
  logic [3:0]  slot_nib;
  logic [7:0]  sel_mask;

`ifdef SEG_LZB_EN
  logic [7:0] lz_mask;

  seg_lzb_mask u_lzb (
    .val (cur_reg),
    .lz  (lz_mask)
  );

  assign sel_mask = SEL_MASK & lz_mask;
`else
  assign sel_mask = SEL_MASK;
`endif

  // Outputs are registered, so each branch prepares the outputs of the state
  // being entered: the registers show that state's transaction next cycle.
  always_comb begin
    state_next  = state_reg;
    idx_next    = idx_reg;
    cur_next    = cur_reg;
    shadow_next = shadow_reg;
    req_next    = 1'b0;
    addr_next   = addr_reg;
    wdata_next  = wdata_reg;
    load_slot   = 1'b0;
    slot_src    = cur_reg;
    slot_idx    = idx_reg + 3'd1;
    slot_nib    = 4'h0;

    case (state_reg)
      INIT: begin
        // First cycle out of reset issues the clear; once it is on the bus, move on.
        if (req_reg) begin
          state_next = IDLE;
        end else begin
          req_next    = 1'b1;
          addr_next   = BASE_ADDR + {20'b0, SEG_OFF_RES};
          wdata_next  = 32'h0;
          shadow_next = 32'h0;
        end
      end
      IDLE: begin
        if (bus.val_valid_i && ready_reg) begin
          cur_next   = bus.val_i;
          idx_next   = 3'd0;
          state_next = SCAN;
          load_slot  = 1'b1;
          slot_src   = bus.val_i;
          slot_idx   = 3'd0;
        end
      end
      SCAN: begin
        if (idx_reg == 3'(SEG_NUM_DIGITS - 1)) begin
          state_next = SEL;
          req_next   = 1'b1;
          addr_next  = BASE_ADDR + {20'b0, SEG_OFF_SEL};
          wdata_next = {24'b0, sel_mask};
        end else begin
          idx_next  = idx_reg + 3'd1;
          load_slot = 1'b1;
        end
      end
      SEL:     state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = INIT;
    endcase

    // A digit slot writes only when the digit differs from what is displayed.
    if (load_slot) begin
      slot_nib = seg_nib(slot_src, slot_idx);
      if (slot_nib != seg_nib(shadow_reg, slot_idx)) begin
        req_next   = 1'b1;
        addr_next  = seg_digit_addr(BASE_ADDR, slot_idx);
        wdata_next = {28'b0, slot_nib};
        shadow_next[{slot_idx, 2'b00} +: 4] = slot_nib;
      end
    end

    ready_next = (state_next == IDLE);
    busy_next  = (state_next != IDLE);
    done_next  = (state_next == DONE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLK100) begin
    if (!resetn) begin
      state_reg  <= INIT;
      idx_reg    <= 3'd0;
      cur_reg    <= 32'h0;
      shadow_reg <= 32'h0;
      req_reg    <= 1'b0;
      addr_reg   <= 32'h0;
      wdata_reg  <= 32'h0;
      ready_reg  <= 1'b0;
      busy_reg   <= 1'b1;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      idx_reg    <= idx_next;
      cur_reg    <= cur_next;
      shadow_reg <= shadow_next;
      req_reg    <= req_next;
      addr_reg   <= addr_next;
      wdata_reg  <= wdata_next;
      ready_reg  <= ready_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
    end
  end

  assign bus.req_o       = req_reg;
  assign bus.we_o        = req_reg;
  assign bus.addr_o      = addr_reg;
  assign bus.wdata_o     = wdata_reg;
  assign bus.val_ready_o = ready_reg;
  assign bus.busy_o      = busy_reg;
  assign bus.done_o      = done_reg;

endmodule

// File: tb/tb_seg_update_master.sv
// Bench for seg_update_master: table of update values with hand-derived
// digit-write counts and select data, a scoreboard of expected bus writes
// and done pulses, and hand sequences for reset and back-to-back requests.
module tb_seg_update_master;
  import seg_pkg::*;

  localparam logic [31:0] BASE = 32'h4000_1000;
`ifdef SEG_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic CLK100 = 1'b0;
  logic resetn = 1'b0;
  always #5 CLK100 = ~CLK100;

  seg_update_master_if bus();

  seg_update_master #(
    .BASE_ADDR (BASE),
    .SEL_MASK  (8'hFF)
  ) dut (
    .CLK100 (CLK100),
    .resetn (resetn),
    .bus    (bus)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } exp_wr_t;

  typedef struct {
    logic [31:0] val;
    int          nwr;
    logic [7:0]  sel;
  } vec_t;

  exp_wr_t     exp_q[$];
  int          done_q[$];
  int          cyc = 0;
  int          n_vec = 0;
  int          n_miss = 0;
  bit          mon_en = 1'b0;
  int          dig_cnt = 0;
  logic [31:0] model_shadow = 32'h0;

  always @(posedge CLK100) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (!ok) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, need 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Expected transactions of one accepted value, handshake seen in cycle t.
  task automatic push_update(input logic [31:0] v, input logic [7:0] sel, input int t);
    exp_wr_t e;
    for (int i = 0; i < 8; i++) begin
      if (v[4*i +: 4] != model_shadow[4*i +: 4]) begin
        e.addr = BASE + 32'(4 * i);
        e.data = {28'b0, v[4*i +: 4]};
        e.cyc  = t + 1 + i;
        exp_q.push_back(e);
        model_shadow[4*i +: 4] = v[4*i +: 4];
      end
    end
    e.addr = BASE + 32'h20;
    e.data = {24'b0, sel};
    e.cyc  = t + 9;
    exp_q.push_back(e);
    done_q.push_back(t + 10);
  endtask

  task automatic monitor();
    exp_wr_t e;
    int      d;
    forever begin
      @(negedge CLK100);
      if (mon_en) begin
        if (bus.req_o === 1'b1) begin
          if (bus.addr_o - BASE < 32'h20) dig_cnt++;
          if (exp_q.size() == 0) begin
            chk(1'b0, "unexpected_write", bus.addr_o, 32'h0);
          end else begin
            e = exp_q.pop_front();
            chk(bus.addr_o === e.addr, "write_addr", bus.addr_o, e.addr);
            chk(bus.wdata_o === e.data, "write_data", bus.wdata_o, e.data);
            chk(cyc == e.cyc, "write_cycle", 32'(cyc), 32'(e.cyc));
          end
        end
        if (bus.req_o === 1'b1 || bus.we_o === 1'b1)
          chk(bus.we_o === bus.req_o, "we_eq_req", {31'b0, bus.we_o}, {31'b0, bus.req_o});
        if (bus.val_ready_o === 1'b1)
          chk(bus.busy_o === 1'b0, "ready_while_busy", {31'b0, bus.busy_o}, 32'h0);
        if (bus.done_o === 1'b1) begin
          if (done_q.size() == 0) begin
            chk(1'b0, "unexpected_done", 32'(cyc), 32'h0);
          end else begin
            d = done_q.pop_front();
            chk(cyc == d, "done_cycle", 32'(cyc), 32'(d));
          end
        end
      end
    end
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 30 && (exp_q.size() != 0 || done_q.size() != 0); k++)
      @(negedge CLK100);
    chk(exp_q.size() == 0 && done_q.size() == 0, "drain_timeout",
        32'(exp_q.size() + done_q.size()), 32'h0);
  endtask

  // Present v until accepted; returns the handshake cycle or -1 on timeout.
  task automatic handshake(input logic [31:0] v, input logic [7:0] sel, output int t);
    bit got = 1'b0;
    t = -1;
    @(negedge CLK100);
    bus.val_i       = v;
    bus.val_valid_i = 1'b1;
    for (int k = 0; k < 40 && !got; k++) begin
      if (bus.val_ready_o === 1'b1) got = 1'b1;
      else @(negedge CLK100);
    end
    if (!got) begin
      chk(1'b0, "accept_timeout", 32'h0, 32'h1);
      bus.val_valid_i = 1'b0;
    end else begin
      t = cyc;
      dig_cnt = 0;
      push_update(v, sel, t);
      @(posedge CLK100);
      #1 bus.val_valid_i = 1'b0;
    end
  endtask

  task automatic do_update(input logic [31:0] v, input int nwr, input logic [7:0] sel);
    int t;
    handshake(v, sel, t);
    if (t >= 0) begin
      wait_drain();
      chk(dig_cnt == nwr, "digit_writes", 32'(dig_cnt), 32'(nwr));
      $display("update val=0x%08h sel=0x%02h digit_writes=%0d accepted_cycle=%0d", v, sel, dig_cnt, t);
    end
  endtask

  task automatic do_reset();
    int r;
    @(posedge CLK100);
    #1 resetn = 1'b0;
    @(posedge CLK100);
    #1;
    exp_q.delete();
    done_q.delete();
    model_shadow = 32'h0;
    mon_en = 1'b1;
    @(negedge CLK100);
    chk(bus.req_o === 1'b0, "rst_req", {31'b0, bus.req_o}, 32'h0);
    chk(bus.we_o === 1'b0, "rst_we", {31'b0, bus.we_o}, 32'h0);
    chk(bus.addr_o === 32'h0, "rst_addr", bus.addr_o, 32'h0);
    chk(bus.wdata_o === 32'h0, "rst_wdata", bus.wdata_o, 32'h0);
    chk(bus.val_ready_o === 1'b0, "rst_ready", {31'b0, bus.val_ready_o}, 32'h0);
    chk(bus.busy_o === 1'b1, "rst_busy", {31'b0, bus.busy_o}, 32'h1);
    chk(bus.done_o === 1'b0, "rst_done", {31'b0, bus.done_o}, 32'h0);
    @(posedge CLK100);
    #1 resetn = 1'b1;
    r = cyc;
    exp_q.push_back('{addr: BASE + 32'h28, data: 32'h0, cyc: r + 1});
    @(negedge CLK100);
    @(negedge CLK100);
    chk(bus.val_ready_o === 1'b0, "init_ready_low", {31'b0, bus.val_ready_o}, 32'h0);
    @(negedge CLK100);
    chk(bus.val_ready_o === 1'b1, "init_ready_rise", {31'b0, bus.val_ready_o}, 32'h1);
    chk(exp_q.size() == 0, "init_clear_seen", 32'(exp_q.size()), 32'h0);
    $display("reset released at cycle %0d, clear write expected at %0d", r, r + 1);
  endtask

  vec_t vecs[8];

  initial begin
    int t;
    int last;
    int n_acc;

    vecs[0] = '{32'h1234_5678, 8, 8'hFF};
    vecs[1] = '{32'h1234_5679, 1, 8'hFF};
    vecs[2] = '{32'h1234_5679, 0, 8'hFF};
    vecs[3] = '{32'h0000_0A05, 8, LZB ? 8'h07 : 8'hFF};
    vecs[4] = '{32'h0000_0000, 2, LZB ? 8'h01 : 8'hFF};
    vecs[5] = '{32'hFFFF_FFFF, 8, 8'hFF};
    vecs[6] = '{32'h0F0F_0F0F, 4, LZB ? 8'h7F : 8'hFF};
    vecs[7] = '{32'h8000_0000, 5, 8'hFF};

    bus.val_i       = 32'h0;
    bus.val_valid_i = 1'b0;
    fork
      monitor();
    join_none

    do_reset();

    // Zero value straight after the clear: nothing changes, select only.
    do_update(32'h0000_0000, 0, LZB ? 8'h01 : 8'hFF);

    for (int i = 0; i < 8; i++)
      do_update(vecs[i].val, vecs[i].nwr, vecs[i].sel);

    // Reset during cycle T+4 of a full update abandons it; the next full
    // update starts from a cleared shadow and writes every digit.
    handshake(32'hFFFF_FFFF, 8'hFF, t);
    do begin
      @(posedge CLK100);
      #1;
    end while (cyc < t + 3);
    do_reset();
    do_update(32'hFFFF_FFFF, 8, 8'hFF);

    // Valid held high: one accept every 11 cycles.
    last  = -1;
    n_acc = 0;
    @(negedge CLK100);
    bus.val_i       = 32'hFFFF_FFFF;
    bus.val_valid_i = 1'b1;
    for (int k = 0; k < 50; k++) begin
      if (bus.val_ready_o === 1'b1) begin
        t = cyc;
        push_update(32'hFFFF_FFFF, 8'hFF, t);
        if (last >= 0) chk(t - last == 11, "accept_spacing", 32'(t - last), 32'd11);
        $display("continuous accept at cycle %0d", t);
        last = t;
        n_acc++;
      end
      @(negedge CLK100);
    end
    bus.val_valid_i = 1'b0;
    chk(n_acc == 5, "accept_count", 32'(n_acc), 32'd5);
    wait_drain();

    chk(exp_q.size() == 0 && done_q.size() == 0, "scoreboard_empty",
        32'(exp_q.size() + done_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got cycle %0d, need finish", cyc);
    $fatal(1, "bench timeout");
  end

endmodule
